// File: rtl/tdm_demux8_latch.sv
// Receive end of an 8:1 TDM link: serial bits land in an addressed latch bank and
// complete frames are committed to Y with a VALID strobe. Optional parity stage: DEMUX8_PARITY_EN.
`timescale 1ns/1ps

module tdm_demux8_latch (
    input  logic       CLK,
    input  logic       RST,
    input  logic       D,
    input  logic       EN,
    input  logic       SYNC,
    output logic       S,
    output logic       T,
    output logic       U,
    output logic [7:0] Q,
    output logic [7:0] Y,
    output logic       VALID,
    output logic       ERR
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef DEMUX8_PARITY_EN
    localparam logic [1:0] ST_PAR   = 2'd2;
`endif

    logic [1:0] state_q, state_d;
    logic [2:0] addr_q, addr_d;
    logic [7:0] q_q, q_d;
    logic [7:0] y_q, y_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        q_d     = q_q;
        y_d     = y_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                addr_d = 3'd0;
                if (EN && SYNC) begin
                    q_d[0]  = D;
                    addr_d  = 3'd1;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (EN) begin
                    if (SYNC) begin
                        // A fresh SYNC mid-frame abandons the partial frame and restarts at bit 0.
                        err_d  = 1'b1;
                        q_d[0] = D;
                        addr_d = 3'd1;
                    end else begin
                        q_d[addr_q] = D;
                        if (addr_q == 3'd7) begin
`ifdef DEMUX8_PARITY_EN
                            state_d = ST_PAR;
`else
                            y_d     = {D, q_q[6:0]};
                            valid_d = 1'b1;
                            addr_d  = 3'd0;
                            state_d = ST_IDLE;
`endif
                        end else begin
                            addr_d = addr_q + 3'd1;
                        end
                    end
                end
            end

`ifdef DEMUX8_PARITY_EN
            ST_PAR: begin
                if (EN) begin
                    if (SYNC) begin
                        err_d   = 1'b1;
                        q_d[0]  = D;
                        addr_d  = 3'd1;
                        state_d = ST_SHIFT;
                    end else begin
                        // Even parity: the parity bit equals the XOR of the eight data bits.
                        if (D == ^q_q) begin
                            y_d     = q_q;
                            valid_d = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                        end
                        addr_d  = 3'd0;
                        state_d = ST_IDLE;
                    end
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                addr_d  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            addr_q  <= 3'd0;
            q_q     <= 8'h00;
            y_q     <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            q_q     <= q_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign S     = addr_q[0];
    assign T     = addr_q[1];
    assign U     = addr_q[2];
    assign Q     = q_q;
    assign Y     = y_q;
    assign VALID = valid_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_tdm_demux8_latch.sv
// Directed bench for tdm_demux8_latch: vector table for the first frame plus
// hand-written sequences for gaps, mid-frame SYNC, back-to-back frames, reset and parity.
`timescale 1ns/1ps

module tb_tdm_demux8_latch;

    logic       CLK = 1'b0;
    logic       RST;
    logic       D;
    logic       EN;
    logic       SYNC;
    logic       S, T, U;
    logic [7:0] Q, Y;
    logic       VALID, ERR;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       en;
        logic       sync;
        logic       d;
        logic [2:0] addr;
        logic [7:0] q;
        logic [7:0] y;
        logic       valid;
        logic       err;
    } vec_t;

    vec_t vecs [10];

    tdm_demux8_latch dut (
        .CLK   (CLK),
        .RST   (RST),
        .D     (D),
        .EN    (EN),
        .SYNC  (SYNC),
        .S     (S),
        .T     (T),
        .U     (U),
        .Q     (Q),
        .Y     (Y),
        .VALID (VALID),
        .ERR   (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic sync, input logic d);
        EN   = en;
        SYNC = sync;
        D    = d;
        @(posedge CLK);
        #1;
    endtask

    // Drives the final data bit (and the parity bit when enabled) and checks the commit.
    task automatic finishFrame(input string tag, input logic [7:0] data);
`ifdef DEMUX8_PARITY_EN
        applyStimulus(1'b1, 1'b0, data[7]);
        checkOutput({tag, ".par_addr"}, {5'b0, U, T, S}, 8'd7);
        checkOutput({tag, ".par_valid"}, {7'b0, VALID}, 8'd0);
        applyStimulus(1'b1, 1'b0, ^data);
`else
        applyStimulus(1'b1, 1'b0, data[7]);
`endif
        checkOutput({tag, ".valid"}, {7'b0, VALID}, 8'd1);
        checkOutput({tag, ".err"}, {7'b0, ERR}, 8'd0);
        checkOutput({tag, ".y"}, Y, data);
        checkOutput({tag, ".addr"}, {5'b0, U, T, S}, 8'd0);
    endtask

    // Sends a full frame; gapAfter >= 0 inserts 3 idle EN cycles after that bit index.
    task automatic sendFrame(input string tag, input logic [7:0] data, input int gapAfter);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, (i == 0), data[i]);
            checkOutput($sformatf("%s.addr%0d", tag, i), {5'b0, U, T, S}, 8'(i + 1));
            checkOutput($sformatf("%s.valid%0d", tag, i), {7'b0, VALID}, 8'd0);
            checkOutput($sformatf("%s.err%0d", tag, i), {7'b0, ERR}, 8'd0);
            if (i == gapAfter) begin
                for (int g = 0; g < 3; g++) begin
                    applyStimulus(1'b0, 1'b0, ~data[i + 1]);
                    checkOutput($sformatf("%s.gap_addr%0d", tag, g), {5'b0, U, T, S}, 8'(i + 1));
                    checkOutput($sformatf("%s.gap_valid%0d", tag, g), {7'b0, VALID}, 8'd0);
                end
            end
        end
        finishFrame(tag, data);
        checkOutput({tag, ".q"}, Q, data);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 3'd1, 8'h01, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 3'd2, 8'h01, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 3'd3, 8'h05, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 3'd4, 8'h0D, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 3'd5, 8'h0D, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 3'd5, 8'h0D, 8'h00, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 3'd6, 8'h0D, 8'h00, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 3'd7, 8'h4D, 8'h00, 1'b0, 1'b0};

        RST  = 1'b1;
        EN   = 1'b0;
        SYNC = 1'b0;
        D    = 1'b0;
        #12;
        checkOutput("rst.addr", {5'b0, U, T, S}, 8'd0);
        checkOutput("rst.q", Q, 8'h00);
        checkOutput("rst.y", Y, 8'h00);
        checkOutput("rst.valid", {7'b0, VALID}, 8'd0);
        checkOutput("rst.err", {7'b0, ERR}, 8'd0);
        RST = 1'b0;

        // First frame 8'h4D, preceded by ignored EN-only and SYNC-only cycles
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].en, vecs[i].sync, vecs[i].d);
            checkOutput($sformatf("vec%0d.addr", i), {5'b0, U, T, S}, {5'b0, vecs[i].addr});
            checkOutput($sformatf("vec%0d.q", i), Q, vecs[i].q);
            checkOutput($sformatf("vec%0d.y", i), Y, vecs[i].y);
            checkOutput($sformatf("vec%0d.valid", i), {7'b0, VALID}, {7'b0, vecs[i].valid});
            checkOutput($sformatf("vec%0d.err", i), {7'b0, ERR}, {7'b0, vecs[i].err});
        end
        finishFrame("f1", 8'h4D);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("f1.valid_once", {7'b0, VALID}, 8'd0);
        checkOutput("f1.y_hold", Y, 8'h4D);

        // Same frame with a 3-cycle EN gap after bit 3
        sendFrame("gap", 8'h4D, 3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("gap.valid_once", {7'b0, VALID}, 8'd0);

        // Mid-frame SYNC at address 5, then the restarted frame commits as 8'h3C
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, (i == 0), 1'b1);
        checkOutput("msync.pre_addr", {5'b0, U, T, S}, 8'd5);
        checkOutput("msync.pre_q", Q, 8'h5F);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("msync.err", {7'b0, ERR}, 8'd1);
        checkOutput("msync.valid", {7'b0, VALID}, 8'd0);
        checkOutput("msync.addr", {5'b0, U, T, S}, 8'd1);
        checkOutput("msync.q", Q, 8'h5E);
        checkOutput("msync.y", Y, 8'h4D);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("msync.err_once", {7'b0, ERR}, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("msync.addr7", {5'b0, U, T, S}, 8'd7);
        finishFrame("msync", 8'h3C);
        checkOutput("msync.qfinal", Q, 8'h3C);

        // Back-to-back frames with no idle cycle between them
        sendFrame("b2b_a", 8'hA5, -1);
        sendFrame("b2b_b", 8'h3C, -1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("b2b.valid_once", {7'b0, VALID}, 8'd0);
        checkOutput("b2b.y", Y, 8'h3C);

        // Asynchronous reset at address 4
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, (i == 0), 1'b1);
        checkOutput("arst.pre_addr", {5'b0, U, T, S}, 8'd4);
        EN = 1'b0;
        #2 RST = 1'b1;
        #1;
        checkOutput("arst.addr", {5'b0, U, T, S}, 8'd0);
        checkOutput("arst.q", Q, 8'h00);
        checkOutput("arst.y", Y, 8'h00);
        checkOutput("arst.valid", {7'b0, VALID}, 8'd0);
        #2 RST = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("arst.post_valid", {7'b0, VALID}, 8'd0);
        sendFrame("ff", 8'hFF, -1);

`ifdef DEMUX8_PARITY_EN
        // Parity mismatch: 8'h4D needs parity 0, send 1
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, (i == 0), 8'h4D >> i);
        checkOutput("pbad.addr7", {5'b0, U, T, S}, 8'd7);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("pbad.err", {7'b0, ERR}, 8'd1);
        checkOutput("pbad.valid", {7'b0, VALID}, 8'd0);
        checkOutput("pbad.y", Y, 8'hFF);
        checkOutput("pbad.addr", {5'b0, U, T, S}, 8'd0);
        sendFrame("pgood", 8'h4D, -1);
`endif

        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("end.valid", {7'b0, VALID}, 8'd0);
        checkOutput("end.err", {7'b0, ERR}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
